ay_bus_master: RTL and testbench
================================

# ay_bus_master

Bus initiator that generates timed AY-8910 style bus cycles (BDIR/BC1/BC2/A8/A9_n plus an 8-bit data bus) from a simple request/ready handshake. It is the driving end of the AY bus that TurboFMpro decodes. It serves as the synthesizable Z80-side stimulus generator in simulation, and as the AY-bus front end of a host-side FPGA controller. It issues three cycle types: register-number latch, data write and data read, each with programmable setup, strobe and hold lengths.

## Interface
Parameters:
- SETUP_CYC, default 2: fclk cycles data/idle bus is presented before strobe; legal range 1..15.
- STROBE_CYC, default 4: fclk cycles BDIR/BC1 held active; legal range 1..15.
- HOLD_CYC, default 2: fclk cycles data held after strobe release; legal range 1..15.

Ports:
- fclk  in  1  single clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req  in  1  request; accepted on a rising fclk edge where req=1, ready=1, rst=0 and op≠11.
- op  in  2  cycle type: 00 latch register number, 01 write data, 10 read data, 11 reserved.
- wdata  in  8  byte for op 00/01, sampled at accept.
- ready  out  1  block idle and able to accept.
- done  out  1  one-cycle pulse at completion of every accepted cycle.
- rdata  out  8  last byte read; updated only by op 10.
- bdir  out  1  AY BDIR.
- bc1  out  1  AY BC1.
- bc2  out  1  AY BC2, constant 1.
- a8  out  1  AY A8, constant 1.
- a9_n  out  1  AY A9_n, constant 0.
- ayd_out  out  8  data bus drive value.
- ayd_oe  out  1  data bus output enable; the top level builds the tristate.
- ayd_in  in  8  data bus sampled value.

## Operation
- All outputs are registered. Reset values: ready=1, done=0, rdata=8'h00, bdir=0, bc1=0, ayd_oe=0, ayd_out=8'h00. bc2, a8 and a9_n are constant.
- FSM states: IDLE, SETUP, STROBE, HOLD. A 4-bit down-counter times each phase.
- IDLE:
  - ready=1 and bus is idle (bdir=bc1=0, ayd_oe=0).
  - On accept: latch op and wdata, load counter with SETUP_CYC-1, go to SETUP. ready=0 from the next cycle.
- op=11 is never accepted. ready stays 1, no bus activity, no done.
- SETUP:
  - bdir=bc1=0.
  - For op 00/01: ayd_oe=1 and ayd_out=latched wdata.
  - For op 10: ayd_oe=0.
  - On counter=0: load STROBE_CYC-1, go to STROBE.
- STROBE:
  - {bdir,bc1} = 11 for op 00, 10 for op 01, 01 for op 10.
  - ayd_oe/ayd_out as in SETUP.
  - On counter=0: for op 10, register rdata <= ayd_in on this edge. Load HOLD_CYC-1, go to HOLD.
- HOLD:
  - bdir=bc1=0.
  - For writes, ayd_oe and ayd_out stay held.
  - On counter=0: go to IDLE with done=1 and ready=1 in that same cycle, and ayd_oe=0.
- Back-to-back: a req accepted in the done cycle starts a new SETUP on the next cycle. There is no extra idle cycle.
- wdata/op changes after accept are ignored. req held high after completion is treated as a new request.
- rst mid-cycle (any state): next cycle all outputs take reset values and the FSM is in IDLE. No done is produced. A read aborted by reset leaves rdata=8'h00.
- bdir and bc1 change only at phase boundaries. They are never active while ayd_out changes.

## Timing
- Accept edge = E0. Cycle k = the k-th cycle after E0. S=SETUP_CYC, T=STROBE_CYC, H=HOLD_CYC.
- Cycles 1..S: SETUP.
- Cycles S+1..S+T: strobe active.
- Cycles S+T+1..S+T+H: HOLD.
- Cycle S+T+H+1: done=1, ready=1.
- Write ayd_oe=1 over cycles 1..S+T+H.
- Read sample edge = the edge ending cycle S+T. rdata is valid from cycle S+T+1 onward.
- Defaults: strobe in cycles 3..6, done in cycle 9. Throughput is one cycle per 9 fclk back-to-back.
- Minimum parameters (1/1/1): strobe in cycle 2, done in cycle 4.

## Test plan
- Reset mid-strobe: start op=01 wdata=8'h77 and assert rst in cycle 4 for 3 cycles. Required: next cycle bdir=bc1=0, ayd_oe=0, ready=1, done=0, rdata=8'h00. The SAA checker records no write.
- Address latch: op=00, wdata=8'h2B, defaults. Required: {bdir,bc1}=11 in cycles 3..6; ayd_oe=1 with ayd_out=8'h2B in cycles 1..8; done in cycle 9. Through TurboFMpro, the ym_checker adr reads 8'h2B.
- Data write: op=01, wdata=8'hA5. Required: {bdir,bc1}=10 in cycles 3..6; the ym_checker wrdat reads 8'hA5.
- Read: op=10 with the responder driving ayd_in=8'h5C while bc1=1. Required: {bdir,bc1}=01 in cycles 3..6; ayd_oe=0 throughout; rdata=8'h5C in the done cycle and held afterwards.
- Back-to-back: req held high with op=00 then op=01 switched in the done cycle. Required: second SETUP starts in cycle 10 and second done arrives in cycle 18. op=11 with req=1: ready stays 1, bdir=bc1=0, no done for 20 cycles.
- Parameter corner: S=T=H=1 with op=01, then S=T=H=15. Required: done in cycle 4 and in cycle 46 respectively.

Source files
------------

// File: rtl/ay_bus_master.sv
// AY-8910 style bus initiator: turns a req/ready handshake into timed
// latch / write / read bus cycles with programmable setup, strobe and hold.
module ay_bus_master #(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 4,
  parameter int unsigned HOLD_CYC   = 2
) (
  input  logic       fclk,
  input  logic       rst,
  input  logic       req,
  input  logic [1:0] op,
  input  logic [7:0] wdata,
  output logic       ready,
  output logic       done,
  output logic [7:0] rdata,
  output logic       bdir,
  output logic       bc1,
  output logic       bc2,
  output logic       a8,
  output logic       a9_n,
  output logic [7:0] ayd_out,
  output logic       ayd_oe,
  input  logic [7:0] ayd_in
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

  localparam logic [1:0] OP_LATCH = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam logic [3:0] LD_SETUP  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] LD_STROBE = 4'(STROBE_CYC - 1);
  localparam logic [3:0] LD_HOLD   = 4'(HOLD_CYC - 1);

  state_t     r_state, w_nxt_state;
  logic [3:0] r_cnt, w_nxt_cnt;
  logic [1:0] r_op, w_nxt_op;
  logic       w_nxt_done;

  logic       r_ready, r_done, r_bdir, r_bc1, r_oe;
  logic [7:0] r_rdata, r_dout;

  logic       w_accept, w_cnt_zero, w_sample;
  logic       w_nxt_strobe, w_nxt_drive;

  // r_ready mirrors "state is IDLE", so it doubles as the accept qualifier.
  assign w_accept   = req && r_ready && (op != OP_RSVD);
  assign w_cnt_zero = (r_cnt == 4'd0);
  assign w_sample   = (r_state == S_STROBE) && w_cnt_zero && (r_op == OP_READ);

  always_ff @(posedge fclk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_op    <= OP_LATCH;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_op    <= w_nxt_op;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_op    = r_op;
    w_nxt_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_nxt_state = S_SETUP;
          w_nxt_cnt   = LD_SETUP;
          w_nxt_op    = op;
        end
      end
      S_SETUP: begin
        if (w_cnt_zero) begin
          w_nxt_state = S_STROBE;
          w_nxt_cnt   = LD_STROBE;
        end else begin
          w_nxt_cnt = r_cnt - 4'd1;
        end
      end
      S_STROBE: begin
        if (w_cnt_zero) begin
          w_nxt_state = S_HOLD;
          w_nxt_cnt   = LD_HOLD;
        end else begin
          w_nxt_cnt = r_cnt - 4'd1;
        end
      end
      S_HOLD: begin
        if (w_cnt_zero) begin
          w_nxt_state = S_IDLE;
          w_nxt_done  = 1'b1;
        end else begin
          w_nxt_cnt = r_cnt - 4'd1;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // phase the FSM enters, not the one it leaves.
  assign w_nxt_strobe = (w_nxt_state == S_STROBE);
  assign w_nxt_drive  = (w_nxt_state != S_IDLE) && (w_nxt_op != OP_READ);

  always_ff @(posedge fclk) begin
    if (rst) begin
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_bdir  <= 1'b0;
      r_bc1   <= 1'b0;
      r_oe    <= 1'b0;
      r_dout  <= 8'h00;
      r_rdata <= 8'h00;
    end else begin
      r_ready <= (w_nxt_state == S_IDLE);
      r_done  <= w_nxt_done;
      // op 00 -> 11, op 01 -> 10, op 10 -> 01
      r_bdir  <= w_nxt_strobe && (w_nxt_op != OP_READ);
      r_bc1   <= w_nxt_strobe && (w_nxt_op != OP_WRITE);
      r_oe    <= w_nxt_drive;
      if (w_accept && (op != OP_READ)) r_dout <= wdata;
      if (w_sample) r_rdata <= ayd_in;
    end
  end

  assign ready   = r_ready;
  assign done    = r_done;
  assign rdata   = r_rdata;
  assign bdir    = r_bdir;
  assign bc1     = r_bc1;
  assign ayd_oe  = r_oe;
  assign ayd_out = r_dout;
  assign bc2     = 1'b1;
  assign a8      = 1'b1;
  assign a9_n    = 1'b0;

endmodule

// File: tb/tb_ay_bus_master.sv
// Bench for ay_bus_master: three instances (default, 1/1/1, 15/15/15) checked
// every cycle against a cycle-index timeline model plus directed literal checks.
module tb_ay_bus_master;

  logic       fclk = 1'b0;
  logic       rst  [3];
  logic       req  [3];
  logic [1:0] op   [3];
  logic [7:0] wdata[3];
  logic [7:0] rsp  [3];
  logic       ready[3], done[3], bdir[3], bc1[3], bc2[3], a8[3], a9_n[3], ayd_oe[3];
  logic [7:0] rdata[3], ayd_out[3], ayd_in[3];

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // model state: mk = cycle index since accept (0 = idle, never accepted)
  int         mk  [3];
  logic [1:0] mop [3];
  logic [7:0] mout[3];
  logic [7:0] mrd [3];

  always #5 fclk = ~fclk;

  // responder drives the bus only while the DUT strobes a read
  for (genvar g = 0; g < 3; g++) begin : g_rsp
    assign ayd_in[g] = (bc1[g] && !bdir[g]) ? rsp[g] : 8'hEE;
  end

  ay_bus_master #(.SETUP_CYC(2), .STROBE_CYC(4), .HOLD_CYC(2)) u_def (
    .fclk(fclk), .rst(rst[0]), .req(req[0]), .op(op[0]), .wdata(wdata[0]),
    .ready(ready[0]), .done(done[0]), .rdata(rdata[0]), .bdir(bdir[0]), .bc1(bc1[0]),
    .bc2(bc2[0]), .a8(a8[0]), .a9_n(a9_n[0]), .ayd_out(ayd_out[0]), .ayd_oe(ayd_oe[0]),
    .ayd_in(ayd_in[0]));

  ay_bus_master #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) u_min (
    .fclk(fclk), .rst(rst[1]), .req(req[1]), .op(op[1]), .wdata(wdata[1]),
    .ready(ready[1]), .done(done[1]), .rdata(rdata[1]), .bdir(bdir[1]), .bc1(bc1[1]),
    .bc2(bc2[1]), .a8(a8[1]), .a9_n(a9_n[1]), .ayd_out(ayd_out[1]), .ayd_oe(ayd_oe[1]),
    .ayd_in(ayd_in[1]));

  ay_bus_master #(.SETUP_CYC(15), .STROBE_CYC(15), .HOLD_CYC(15)) u_max (
    .fclk(fclk), .rst(rst[2]), .req(req[2]), .op(op[2]), .wdata(wdata[2]),
    .ready(ready[2]), .done(done[2]), .rdata(rdata[2]), .bdir(bdir[2]), .bc1(bc1[2]),
    .bc2(bc2[2]), .a8(a8[2]), .a9_n(a9_n[2]), .ayd_out(ayd_out[2]), .ayd_oe(ayd_oe[2]),
    .ayd_in(ayd_in[2]));

  function automatic int ps(int i); return (i == 0) ? 2 : (i == 1) ? 1 : 15; endfunction
  function automatic int pt(int i); return (i == 0) ? 4 : (i == 1) ? 1 : 15; endfunction
  function automatic int ph(int i); return (i == 0) ? 2 : (i == 1) ? 1 : 15; endfunction

  task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d t=%0t got=%0h want=%0h", nm, i, $time, act, exp);
    end
  endtask

  // model advance on each rising edge
  always @(posedge fclk) begin
    for (int i = 0; i < 3; i++) begin
      int s, t, n;
      bit rdy;
      s = ps(i); t = pt(i); n = s + t + ph(i);
      if (rst[i]) begin
        mk[i] = 0; mout[i] = 8'h00; mrd[i] = 8'h00;
      end else begin
        if (mk[i] == s + t && mop[i] == 2'b10) mrd[i] = rsp[i];
        rdy = (mk[i] == 0) || (mk[i] == n + 1);
        if (rdy && req[i] && op[i] != 2'b11) begin
          mk[i] = 1; mop[i] = op[i];
          if (op[i] != 2'b10) mout[i] = wdata[i];
        end else if (mk[i] == n + 1) mk[i] = 0;
        else if (mk[i] != 0) mk[i] = mk[i] + 1;
      end
    end
  end

  // per-cycle compare against the timeline model
  always @(negedge fclk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        int s, t, n, k;
        bit str, oe;
        s = ps(i); t = pt(i); n = s + t + ph(i); k = mk[i];
        str = (k >= s + 1) && (k <= s + t);
        oe  = (k >= 1) && (k <= n) && (mop[i] != 2'b10);
        chk("ready", i, 32'(ready[i]), 32'((k == 0) || (k == n + 1)));
        chk("done",  i, 32'(done[i]),  32'(k == n + 1));
        chk("bdir",  i, 32'(bdir[i]),  32'(str && mop[i] != 2'b10));
        chk("bc1",   i, 32'(bc1[i]),   32'(str && mop[i] != 2'b01));
        chk("ayd_oe", i, 32'(ayd_oe[i]), 32'(oe));
        if (oe) chk("ayd_out", i, 32'(ayd_out[i]), 32'(mout[i]));
        chk("rdata", i, 32'(rdata[i]), 32'(mrd[i]));
        chk("const", i, {29'd0, bc2[i], a8[i], a9_n[i]}, 32'b110);
      end
    end
  end

  // issue one op; report done cycle index and check strobe code / first-cycle data
  task automatic run_op(int i, logic [1:0] o, logic [7:0] wd, logic [1:0] code,
                        int sc, output int got);
    int k;
    @(negedge fclk); req[i] = 1'b1; op[i] = o; wdata[i] = wd;
    @(posedge fclk);
    @(negedge fclk); req[i] = 1'b0; op[i] = 2'b11; wdata[i] = ~wd;
    k = 1; got = -1;
    if (o != 2'b10) chk("lit_out_c1", i, 32'(ayd_out[i]), 32'(wd));
    while (k < 100) begin
      if (k == sc) chk("lit_strobe", i, {30'd0, bdir[i], bc1[i]}, 32'(code));
      if (done[i]) begin got = k; break; end
      @(negedge fclk); k++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int d, d1, d2, ndone, k;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; req[i] = 1'b0; op[i] = 2'b00; wdata[i] = 8'h00; rsp[i] = 8'h00;
    end
    rsp[0] = 8'h5C; rsp[2] = 8'hC3;
    @(negedge fclk); chk_en = 1'b1;
    @(negedge fclk);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    @(negedge fclk);
    chk("lit_rst_ready", 0, 32'(ready[0]), 32'd1);
    chk("lit_rst_rdata", 0, 32'(rdata[0]), 32'h00);

    // address latch
    run_op(0, 2'b00, 8'h2B, 2'b11, 3, d);
    chk("lit_latch_done", 0, d, 9);
    // data write
    run_op(0, 2'b01, 8'hA5, 2'b10, 3, d);
    chk("lit_write_done", 0, d, 9);
    // read
    run_op(0, 2'b10, 8'h00, 2'b01, 6, d);
    chk("lit_read_done", 0, d, 9);
    chk("lit_read_rdata", 0, 32'(rdata[0]), 32'h5C);
    repeat (3) @(negedge fclk);
    chk("lit_read_held", 0, 32'(rdata[0]), 32'h5C);

    // back-to-back with op switched in the done cycle
    @(negedge fclk); req[0] = 1'b1; op[0] = 2'b00; wdata[0] = 8'h11;
    @(posedge fclk);
    @(negedge fclk);
    k = 1; d1 = -1; d2 = -1;
    while (k < 100) begin
      if (k == 10) chk("lit_b2b_setup", 0, {23'd0, ayd_oe[0], ayd_out[0]}, 32'h122);
      if (done[0] && d1 < 0) begin
        d1 = k; op[0] = 2'b01; wdata[0] = 8'h22;
      end else if (done[0]) begin
        d2 = k; req[0] = 1'b0; break;
      end
      @(negedge fclk); k++;
    end
    chk("lit_b2b_done1", 0, d1, 9);
    chk("lit_b2b_done2", 0, d2, 18);

    // reserved op must never be accepted
    op[0] = 2'b11; req[0] = 1'b1; ndone = 0;
    repeat (20) begin
      @(negedge fclk);
      if (done[0] || !ready[0] || bdir[0] || bc1[0]) ndone++;
    end
    req[0] = 1'b0;
    chk("lit_rsvd_idle", 0, ndone, 0);

    // reset mid-strobe of a write
    @(negedge fclk); req[0] = 1'b1; op[0] = 2'b01; wdata[0] = 8'h77;
    @(posedge fclk);
    @(negedge fclk); req[0] = 1'b0;
    repeat (3) @(negedge fclk);
    chk("lit_pre_rst_strobe", 0, {30'd0, bdir[0], bc1[0]}, 32'b10);
    rst[0] = 1'b1;
    @(negedge fclk);
    chk("lit_rst_bus", 0, {28'd0, bdir[0], bc1[0], ayd_oe[0], done[0]}, 32'd0);
    chk("lit_rst_rdy", 0, 32'(ready[0]), 32'd1);
    chk("lit_rst_rd", 0, 32'(rdata[0]), 32'h00);
    repeat (2) @(negedge fclk);
    rst[0] = 1'b0;
    repeat (12) @(negedge fclk);
    chk("lit_rst_nodone", 0, 32'(done[0]), 32'd0);

    // parameter corners
    run_op(1, 2'b01, 8'h3C, 2'b10, 2, d);
    chk("lit_min_done", 1, d, 4);
    run_op(1, 2'b00, 8'h81, 2'b11, 2, d);
    chk("lit_min_latch_done", 1, d, 4);
    run_op(2, 2'b01, 8'h96, 2'b10, 16, d);
    chk("lit_max_done", 2, d, 46);
    run_op(2, 2'b10, 8'h00, 2'b01, 30, d);
    chk("lit_max_read_done", 2, d, 46);
    chk("lit_max_rdata", 2, 32'(rdata[2]), 32'hC3);

    repeat (4) @(negedge fclk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
